// File: rtl/uc_multicycle_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// FSM state enum, opcodes, ALU control and datapath mux-select codes.
package uc_multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/uc_multicycle_main_fsm.sv
// Moore main FSM of the multicycle control unit.
// In: clk_i, rst_i (async high), op_i. Out: datapath enables/selects,
// aluOp_o, branch_o, pcUpdate_o (all decoded from the state only).
module main_fsm
    import uc_multicycle_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_i,
    output logic       adrSrc_o,
    output logic       memWrite_o,
    output logic       irWrite_o,
    output logic       regWrite_o,
    output logic [1:0] resSrc_o,
    output logic [1:0] aluSrcA_o,
    output logic [1:0] aluSrcB_o,
    output logic [1:0] aluOp_o,
    output logic       branch_o,
    output logic       pcUpdate_o
);

    state_t state_q, state_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        adrSrc_o   = 1'b0;
        memWrite_o = 1'b0;
        irWrite_o  = 1'b0;
        regWrite_o = 1'b0;
        resSrc_o   = RES_ALUOUT;
        aluSrcA_o  = SRCA_PC;
        aluSrcB_o  = SRCB_RS2;
        aluOp_o    = ALUOP_ADD;
        branch_o   = 1'b0;
        pcUpdate_o = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                irWrite_o  = 1'b1;
                aluSrcB_o  = SRCB_FOUR;
                resSrc_o   = RES_ALU;
                pcUpdate_o = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                aluSrcA_o = SRCA_OLDPC;
                aluSrcB_o = SRCB_IMM;
                // Unknown opcodes fall back to FETCH with no writes.
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                aluSrcA_o = SRCA_RS1;
                aluSrcB_o = SRCB_IMM;
                if (op_i == OP_LW)      state_d = S_MEMREAD;
                else if (op_i == OP_SW) state_d = S_MEMWRITE;
                else                    state_d = S_FETCH;
            end
            S_MEMREAD: begin
                adrSrc_o = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                resSrc_o   = RES_DATA;
                regWrite_o = 1'b1;
            end
            S_MEMWRITE: begin
                adrSrc_o   = 1'b1;
                memWrite_o = 1'b1;
            end
            S_EXECR: begin
                aluSrcA_o = SRCA_RS1;
                aluOp_o   = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcA_o = SRCA_RS1;
                aluSrcB_o = SRCB_IMM;
                aluOp_o   = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite_o = 1'b1;
            end
            S_BEQ: begin
                aluSrcA_o = SRCA_RS1;
                aluOp_o   = ALUOP_SUB;
                branch_o  = 1'b1;
            end
            S_JAL: begin
                aluSrcA_o  = SRCA_OLDPC;
                aluSrcB_o  = SRCB_FOUR;
                pcUpdate_o = 1'b1;
                state_d    = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: rtl/uc_multicycle.sv
// Multicycle RISC-V control unit top: main FSM plus ALU decode,
// immSrc decode and gated write enables. Ports: clk, reset (async high),
// op/f3/f7/zero in; pcWrite..ALUcontrol datapath controls out.
module uc_multicycle
    import uc_multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic       f7,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regWrite,
    output logic [1:0] resSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] immSrc,
    output logic [2:0] ALUcontrol
);

    logic       mem_we, ir_we, reg_we;
    logic       branch, pc_update;
    logic [1:0] alu_op;

    main_fsm u_fsm (
        .clk_i      (clk),
        .rst_i      (reset),
        .op_i       (op),
        .adrSrc_o   (adrSrc),
        .memWrite_o (mem_we),
        .irWrite_o  (ir_we),
        .regWrite_o (reg_we),
        .resSrc_o   (resSrc),
        .aluSrcA_o  (aluSrcA),
        .aluSrcB_o  (aluSrcB),
        .aluOp_o    (alu_op),
        .branch_o   (branch),
        .pcUpdate_o (pc_update)
    );

    // The FSM already sits in FETCH while reset is high; the gate keeps
    // that state's enables from touching PC/IR before reset releases.
    assign pcWrite  = (pc_update | (branch & zero)) & ~reset;
    assign irWrite  = ir_we & ~reset;
    assign regWrite = reg_we & ~reset;
    assign memWrite = mem_we & ~reset;

    always_comb begin
        ALUcontrol = ALU_ADD;
        unique case (alu_op)
            ALUOP_SUB: ALUcontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (f3)
                    // Only R-type (op[5]=1) with f7 set is sub.
                    3'b000:  ALUcontrol = (op[5] & f7) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUcontrol = ALU_SLT;
                    3'b110:  ALUcontrol = ALU_OR;
                    3'b111:  ALUcontrol = ALU_AND;
                    default: ALUcontrol = ALU_ADD;
                endcase
            end
            default: ALUcontrol = ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   immSrc = IMM_S;
            OP_BEQ:  immSrc = IMM_B;
            OP_JAL:  immSrc = IMM_J;
            default: immSrc = IMM_I;
        endcase
    end

endmodule

// File: tb/tb_uc_multicycle.sv
// Bench for uc_multicycle: instruction-level reference model compared
// every cycle, plus hand-computed expectations on key cycles.
module tb_uc_multicycle;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] f3 = 3'd0;
    logic       f7 = 1'b0;
    logic       zero = 1'b0;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite;
    logic [1:0] resSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] ALUcontrol;

    uc_multicycle dut (
        .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7),
        .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc),
        .memWrite(memWrite), .irWrite(irWrite), .regWrite(regWrite),
        .resSrc(resSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .immSrc(immSrc), .ALUcontrol(ALUcontrol)
    );

    always #5 clk = ~clk;

    // [15]pcW [14]adr [13]memW [12]irW [11]regW [10:9]res
    // [8:7]srcA [6:5]srcB [4:3]imm [2:0]alu
    logic [15:0] dv;
    assign dv = {pcWrite, adrSrc, memWrite, irWrite, regWrite,
                 resSrc, aluSrcA, aluSrcB, immSrc, ALUcontrol};

    int n_cmp = 0;
    int n_err = 0;
    bit run = 1'b0;
    int step = 0;
    logic [15:0] cap [0:4];

    localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_R = 3;
    localparam int C_I = 4, C_BEQ = 5, C_JAL = 6;

    function automatic int cls_of(input logic [6:0] o);
        case (o)
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b1100011: return C_BEQ;
            7'b1101111: return C_JAL;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int len_of(input logic [6:0] o);
        case (cls_of(o))
            C_LW:    return 5;
            C_BEQ:   return 3;
            C_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] alu_fn(input logic [6:0] o,
                                          input logic [2:0] a,
                                          input logic b);
        case (a)
            3'd0:    return (o[5] && b) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs for step s of the instruction described by o.
    function automatic logic [15:0] model(input int s,
                                          input logic [6:0] o,
                                          input logic [2:0] a,
                                          input logic b,
                                          input logic z,
                                          input logic rst);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu;
        int c;
        c = cls_of(o);
        {pcw, adr, mw, irw, rw} = 5'b0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        imm = (c == C_SW) ? 2'b01 : (c == C_BEQ) ? 2'b10 :
              (c == C_JAL) ? 2'b11 : 2'b00;
        if (s == 0) begin
            irw = 1; pcw = 1; sb = 2'b10; res = 2'b10;
        end else if (s == 1) begin
            sa = 2'b01; sb = 2'b01;
        end else if (s == 2) begin
            case (c)
                C_LW, C_SW: begin sa = 2'b10; sb = 2'b01; end
                C_R: begin sa = 2'b10; alu = alu_fn(o, a, b); end
                C_I: begin
                    sa = 2'b10; sb = 2'b01; alu = alu_fn(o, a, b);
                end
                C_BEQ: begin sa = 2'b10; alu = 3'b001; pcw = z; end
                C_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
                default: ;
            endcase
        end else if (s == 3) begin
            case (c)
                C_LW:    adr = 1;
                C_SW:    begin adr = 1; mw = 1; end
                default: rw = 1;
            endcase
        end else begin
            res = 2'b01; rw = 1;
        end
        if (rst) {pcw, mw, irw, rw} = 4'b0;
        return {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu};
    endfunction

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) step = 0;
        else if (step >= len_of(op) - 1) step = 0;
        else step = step + 1;
    end

    always @(negedge clk) begin
        if (run) check("cycle", dv, model(step, op, f3, f7, zero, reset));
    end

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
    } vec_t;

    vec_t tab [$];

    task automatic issue(input vec_t v);
        op = v.op; f3 = v.f3; f7 = v.f7; zero = v.z;
    endtask

    task automatic run_instr(input int n);
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            cap[s] = dv;
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tab.push_back('{7'b0000011, 3'd2, 1'b0, 1'b1});
        tab.push_back('{7'b0100011, 3'd2, 1'b0, 1'b1});
        tab.push_back('{7'b0110011, 3'd0, 1'b1, 1'b1});
        tab.push_back('{7'b0110011, 3'd0, 1'b0, 1'b1});
        tab.push_back('{7'b0110011, 3'd7, 1'b0, 1'b1});
        tab.push_back('{7'b0110011, 3'd6, 1'b0, 1'b1});
        tab.push_back('{7'b0110011, 3'd2, 1'b0, 1'b1});
        tab.push_back('{7'b0110011, 3'd1, 1'b0, 1'b1});
        tab.push_back('{7'b0010011, 3'd0, 1'b1, 1'b1});
        tab.push_back('{7'b0010011, 3'd2, 1'b0, 1'b1});
        tab.push_back('{7'b1100011, 3'd0, 1'b0, 1'b1});
        tab.push_back('{7'b1100011, 3'd0, 1'b0, 1'b0});
        tab.push_back('{7'b1101111, 3'd0, 1'b0, 1'b1});
        tab.push_back('{7'b1111111, 3'd0, 1'b0, 1'b1});
        tab.push_back('{7'b0000000, 3'd0, 1'b0, 1'b1});

        run = 1'b1;
        #3;
        check("reset_state", dv, 16'b0_0_0_0_0_10_00_10_00_000);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;

        foreach (tab[i]) begin
            issue(tab[i]);
            run_instr(len_of(tab[i].op));
            case (i)
                0: begin
                    check("lw_wb", 16'({cap[4][11], cap[4][10:9]}),
                          16'b101);
                    check("lw_rw_early", 16'({cap[0][11], cap[1][11],
                          cap[2][11], cap[3][11]}), 16'b0);
                end
                1: begin
                    check("sw_mem", 16'({cap[3][13], cap[3][14],
                          cap[3][4:3]}), 16'b1101);
                    check("sw_no_rw", 16'({cap[0][11], cap[1][11],
                          cap[2][11], cap[3][11], cap[0][13],
                          cap[1][13], cap[2][13]}), 16'b0);
                end
                2: check("r_sub", 16'(cap[2][2:0]), 16'b001);
                4: check("r_and", 16'(cap[2][2:0]), 16'b010);
                8: check("i_add", 16'(cap[2][2:0]), 16'b000);
                10: check("beq_taken", 16'(cap[2][15]), 16'b1);
                11: check("beq_not", 16'(cap[2][15]), 16'b0);
                12: check("jal_pc_rw", 16'({cap[2][15], cap[3][11]}),
                          16'b11);
                13: check("illegal_en", 16'({cap[1][15], cap[1][13],
                          cap[1][12], cap[1][11]}), 16'b0);
                default: ;
            endcase
        end

        // Reset pulsed in the middle of a load's MEMREAD cycle.
        issue(tab[0]);
        run_instr(3);
        reset = 1'b1;
        issue(tab[3]);
        #1;
        check("reset_async", dv, 16'b0_0_0_0_0_10_00_10_00_000);
        @(posedge clk);
        #2;
        reset = 1'b0;
        run_instr(4);
        check("post_reset", 16'({cap[0][12], cap[1][8:7],
              cap[3][11]}), 16'b1011);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uc_multicycle.md
UC_MULTICYCLE -- requirements
Module: uc_multicycle

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces FSM to FETCH.
REQ-003 op  in  7  instruction opcode (instr[6:0]) from instruction register.
REQ-004 f3  in  3  funct3 (instr[14:12]).
REQ-005 f7  in  1  funct7 bit 5 (instr[30]).
REQ-006 zero  in  1  ALU zero flag, same cycle.
REQ-007 pcWrite  out  1  PC register enable.
REQ-008 adrSrc  out  1  memory address mux: 0=PC, 1=ALU result register.
REQ-009 memWrite  out  1  data memory write enable.
REQ-010 irWrite  out  1  instruction register + oldPC enable.
REQ-011 regWrite  out  1  register file write enable.
REQ-012 resSrc  out  2  result mux: 00=ALUOut reg, 01=Data reg, 10=ALU result.
REQ-013 aluSrcA  out  2  00=PC, 01=oldPC, 10=rs1 reg.
REQ-014 aluSrcB  out  2  00=rs2 reg, 01=immExt, 10=constant 4.
REQ-015 immSrc  out  2  00=I, 01=S, 10=B, 11=J; combinational from op.
REQ-016 ALUcontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.

Function
REQ-017 Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-018 FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp=00, resSrc=10, pcUpdate=1; next DECODE.
REQ-019 DECODE: aluSrcA=01, aluSrcB=01, aluOp=00; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, any other->FETCH (illegal, no writes).
REQ-020 MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00; next MEMREAD if op=0000011, MEMWRITE if 0100011.
REQ-021 MEMREAD: resSrc=00, adrSrc=1; next MEMWB.  MEMWB: resSrc=01, regWrite=1; next FETCH.
REQ-022 MEMWRITE: resSrc=00, adrSrc=1, memWrite=1; next FETCH.
REQ-023 EXECR: aluSrcA=10, aluSrcB=00, aluOp=10; EXECI: aluSrcA=10, aluSrcB=01, aluOp=10; both next ALUWB.
REQ-024 ALUWB: resSrc=00, regWrite=1; next FETCH.
REQ-025 BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resSrc=00, branch=1; next FETCH.
REQ-026 JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resSrc=00, pcUpdate=1; next ALUWB.
REQ-027 pcWrite = pcUpdate | (branch & zero), combinational; zero sampled only in BEQ.
REQ-028 Unlisted outputs per state are 0 (don't-care muxes driven 00).
REQ-029 ALU decode: aluOp 00->add; 01->sub; 10 by f3: 000 -> sub if (op[5] & f7) else add, 010->slt, 110->or, 111->and, other->add.
REQ-030 Latencies (cycles): lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.

Reset
REQ-031 reset asserted: state=FETCH immediately (async); pcWrite, irWrite, regWrite, memWrite forced 0 while reset high; other outputs show FETCH values.
REQ-032 Reset mid-instruction abandons it; first clk edge after deassertion performs a full FETCH.

Structure
REQ-033 Shared package holds state enum, opcode constants, ALUcontrol and mux-select encodings.
REQ-034 One sub-module main_fsm (state register, next-state, Moore outputs, aluOp, branch, pcUpdate); ALU decode, immSrc and pcWrite logic in top.

Verification
REQ-035 lw (op=0000011) after reset -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regWrite=1 only in cycle 5, resSrc=01.
REQ-036 sw (op=0100011) -> memWrite=1 only in cycle 4, adrSrc=1, immSrc=01; regWrite never 1.
REQ-037 beq with zero=1 in BEQ -> pcWrite=1 in cycle 3; with zero=0 -> pcWrite=0, back to FETCH.
REQ-038 R-type f3=000, f7=1 -> ALUcontrol=001 in EXECR; f3=111 -> 010; I-type f3=000, f7=1 -> 000 (op[5]=0).
REQ-039 op=1111111 -> DECODE then FETCH, no write enables asserted.
REQ-040 reset pulsed during MEMREAD -> state FETCH asynchronously, all enables 0 while high, normal fetch next edge.
